st_pixel_unpacker: RTL

- Consumes 256-bit Avalon-ST beats from the mSGDMA streaming source (msgdma_0_st_source) and replaces test_st_sink in the FPGA_CLK1_50 domain.
- Unpacks each beat into 8 pixels of 24-bit RGB, one pixel per handshake, with frame/line position flags.
- Output feeds the write side of the dual-clock pixel FIFO that crosses into the 165 MHz rgb_driver domain.

---
 rtl/st_pixel_unpacker_if.sv | 23 ++
 rtl/st_pixel_unpacker.sv | 68 ++++++
 2 files changed

// File: rtl/st_pixel_unpacker_if.sv
// st_pixel_unpacker_if: beat-in / pixel-out stream bundle for the pixel unpacker
interface st_pixel_unpacker_if #(
  parameter int DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0] st_data;
  logic                  valid;
  logic                  ready;
  logic                  frame_restart;
  logic [23:0]           pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_sof;
  logic                  pix_eol;
  logic                  frame_done;
  modport master (
    output st_data, valid, frame_restart, pix_ready,
    input  ready, pix_data, pix_valid, pix_sof, pix_eol, frame_done
  );
  modport slave (
    input  st_data, valid, frame_restart, pix_ready,
    output ready, pix_data, pix_valid, pix_sof, pix_eol, frame_done
  );
endinterface

// File: rtl/st_pixel_unpacker.sv
// st_pixel_unpacker: splits wide Avalon-ST beats into 24-bit RGB pixels, lane 0 first,
// tracking frame position to flag start-of-frame, end-of-line and frame completion.
module st_pixel_unpacker #(
  parameter int DATA_WIDTH = 256,
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080
) (
  input logic               clk,
  input logic               rst_n,
  st_pixel_unpacker_if.slave bus
);
  localparam int LANES = DATA_WIDTH / 32;
  localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;
  localparam int XW    = H_ACTIVE > 1 ? $clog2(H_ACTIVE) : 1;
  localparam int YW    = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [LW-1:0]         lane;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic                  buf_full;
  logic                  frame_done_q;
  logic                  pix_acc;
  logic                  beat_acc;
  logic                  last_lane;
  logic                  x_end;
  logic                  y_end;
  assign last_lane = lane == LW'(LANES - 1);
  assign x_end     = x == XW'(H_ACTIVE - 1);
  assign y_end     = y == YW'(V_ACTIVE - 1);
  // A restart cycle hides the buffered pixel so no handshake can complete under it.
  assign bus.pix_valid  = buf_full && !bus.frame_restart;
  assign bus.pix_data   = buf_q[{lane, 5'd0} +: 24];
  assign pix_acc        = bus.pix_valid && bus.pix_ready;
  assign bus.ready      = rst_n && !bus.frame_restart && (!buf_full || (pix_acc && last_lane));
  assign beat_acc       = bus.valid && bus.ready;
  assign bus.pix_sof    = bus.pix_valid && x == '0 && y == '0;
  assign bus.pix_eol    = bus.pix_valid && x_end;
  assign bus.frame_done = frame_done_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_q        <= '0;
      lane         <= '0;
      buf_full     <= 1'b0;
      x            <= '0;
      y            <= '0;
      frame_done_q <= 1'b0;
    end else if (bus.frame_restart) begin
      lane         <= '0;
      buf_full     <= 1'b0;
      x            <= '0;
      y            <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= pix_acc && x_end && y_end;
      if (beat_acc) begin
        buf_q    <= bus.st_data;
        lane     <= '0;
        buf_full <= 1'b1;
      end else if (pix_acc) begin
        buf_full <= !last_lane;
        lane     <= last_lane ? lane : lane + 1'b1;
      end
      if (pix_acc) begin
        x <= x_end ? '0 : x + 1'b1;
        y <= x_end ? (y_end ? '0 : y + 1'b1) : y;
      end
    end
endmodule
